// File: rtl/x_6k_tap_gen.sv
// x_6k_tap_gen: collects a serial sample stream and, every 6 accepted
// samples, presents the taps x[6k], x[6k-3], x[6k-4], x[6k-5] for y_6k.
module x_6k_tap_gen #(
    parameter int w_in = 5,
    parameter int k_w  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sclr,
    input  logic signed [w_in-1:0] x_in,
    input  logic                   in_valid,
    output logic signed [w_in-1:0] x_6k,
    output logic signed [w_in-1:0] x_6k_3,
    output logic signed [w_in-1:0] x_6k_4,
    output logic signed [w_in-1:0] x_6k_5,
    output logic                   out_valid,
    output logic [k_w-1:0]         k_idx
);

    logic signed [w_in-1:0] h1, h2, h3, h4, h5;
    logic [2:0]             ph;
    logic                   started;
    logic                   tap_ev;

    // A block boundary is an accept while the phase sits at 0
    always_comb begin
        tap_ev = in_valid && (ph == 3'd0);
    end

    // Sample history and phase; a clear discards any partial block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h1 <= '0;
            h2 <= '0;
            h3 <= '0;
            h4 <= '0;
            h5 <= '0;
            ph <= 3'd0;
        end else if (sclr) begin
            h1 <= '0;
            h2 <= '0;
            h3 <= '0;
            h4 <= '0;
            h5 <= '0;
            ph <= 3'd0;
        end else if (in_valid) begin
            h1 <= x_in;
            h2 <= h1;
            h3 <= h2;
            h4 <= h3;
            h5 <= h4;
            ph <= (ph == 3'd5) ? 3'd0 : ph + 3'd1;
        end
    end

    // Tap capture, strobe and block index; taps hold between events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_6k      <= '0;
            x_6k_3    <= '0;
            x_6k_4    <= '0;
            x_6k_5    <= '0;
            out_valid <= 1'b0;
            k_idx     <= '0;
            started   <= 1'b0;
        end else if (sclr) begin
            x_6k      <= '0;
            x_6k_3    <= '0;
            x_6k_4    <= '0;
            x_6k_5    <= '0;
            out_valid <= 1'b0;
            k_idx     <= '0;
            started   <= 1'b0;
        end else begin
            out_valid <= tap_ev;
            if (tap_ev) begin
                x_6k    <= x_in;
                x_6k_3  <= h3;
                x_6k_4  <= h4;
                x_6k_5  <= h5;
                k_idx   <= started ? k_idx + k_w'(1) : '0;
                started <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_x_6k_tap_gen.sv
// tb_x_6k_tap_gen: randomized and directed checks of x_6k_tap_gen
// against a sample-list reference model.
module tb_x_6k_tap_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sclr = 1'b0;
    logic in_valid = 1'b0;
    logic signed [4:0] x_in = '0;
    logic signed [4:0] x_6k, x_6k_3, x_6k_4, x_6k_5;
    logic signed [4:0] y_6k, y_6k_3, y_6k_4, y_6k_5;
    logic out_valid, out_valid2;
    logic [7:0] k_idx;
    logic [1:0] k2_idx;

    int checks = 0;
    int errors = 0;

    // reference model: every sample accepted since the last clear
    logic signed [4:0] smp[$];
    logic ev;
    logic signed [4:0] e6, e3, e4, e5;
    int ek;

    logic [30:0] got;

    always #5 clk = ~clk;

    x_6k_tap_gen #(.w_in(5), .k_w(8)) dut (
        .clk(clk), .rst(rst), .sclr(sclr),
        .x_in(x_in), .in_valid(in_valid),
        .x_6k(x_6k), .x_6k_3(x_6k_3),
        .x_6k_4(x_6k_4), .x_6k_5(x_6k_5),
        .out_valid(out_valid), .k_idx(k_idx)
    );

    x_6k_tap_gen #(.w_in(5), .k_w(2)) dut2 (
        .clk(clk), .rst(rst), .sclr(sclr),
        .x_in(x_in), .in_valid(in_valid),
        .x_6k(y_6k), .x_6k_3(y_6k_3),
        .x_6k_4(y_6k_4), .x_6k_5(y_6k_5),
        .out_valid(out_valid2), .k_idx(k2_idx)
    );

    assign got = {out_valid, x_6k, x_6k_3, x_6k_4,
                  x_6k_5, k_idx, k2_idx};

    function automatic logic [30:0] want_vec();
        return {ev, e6, e3, e4, e5, 8'(ek), 2'(ek)};
    endfunction

    task automatic model_clear();
        smp.delete();
        ev = 1'b0;
        e6 = '0; e3 = '0; e4 = '0; e5 = '0;
        ek = 0;
    endtask

    function automatic logic signed [4:0] past(input int i);
        return (i >= 0) ? smp[i] : 5'sd0;
    endfunction

    // drive one cycle, then advance the model to what should be visible
    task automatic step(input logic signed [4:0] x,
                        input logic v, input logic s);
        int n;
        x_in = x;
        in_valid = v;
        sclr = s;
        @(posedge clk);
        #1;
        sclr = 1'b0;
        in_valid = 1'b0;
        ev = 1'b0;
        if (s) begin
            model_clear();
        end else if (v) begin
            n = smp.size();
            smp.push_back(x);
            if (n % 6 == 0) begin
                ev = 1'b1;
                e6 = x;
                e3 = past(n - 3);
                e4 = past(n - 4);
                e5 = past(n - 5);
                ek = n / 6;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #10;
        checks++;
        if (got !== 31'd0) begin
            errors++;
            $display("FAIL reset got %h want 0", got);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            step(5'sd9, 1'b0, 1'b0);
            checks++;
            if (got !== want_vec()) begin
                errors++;
                $display("FAIL idle got %h want %h", got, want_vec());
            end
        end
    endtask

    task automatic test_ramp(input int gap);
        logic [27:0] tbl [0:2];
        int p;
        tbl[0] = {5'd1, 5'd0, 5'd0, 5'd0, 8'd0};
        tbl[1] = {5'd7, 5'd4, 5'd3, 5'd2, 8'd1};
        tbl[2] = {5'd13, 5'd10, 5'd9, 5'd8, 8'd2};
        p = 0;
        step('0, 1'b0, 1'b1);
        for (int n = 0; n <= 12; n++) begin
            step(5'(n + 1), 1'b1, 1'b0);
            checks++;
            if (got !== want_vec()) begin
                errors++;
                $display("FAIL ramp%0d n=%0d got %h want %h",
                         gap, n, got, want_vec());
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (p > 2 || {x_6k, x_6k_3, x_6k_4, x_6k_5, k_idx}
                             !== tbl[p]) begin
                    errors++;
                    $display("FAIL ramp%0d_pulse%0d got %h want %h",
                             gap, p, {x_6k, x_6k_3, x_6k_4,
                             x_6k_5, k_idx}, tbl[p % 3]);
                end
                p++;
            end
            for (int g = 0; g < gap; g++) begin
                step(5'(n + 20), 1'b0, 1'b0);
                checks++;
                if (got !== want_vec()) begin
                    errors++;
                    $display("FAIL gap%0d n=%0d got %h want %h",
                             gap, n, got, want_vec());
                end
            end
        end
        checks++;
        if (p != 3) begin
            errors++;
            $display("FAIL ramp%0d_pulses got %0d want 3", gap, p);
        end
    endtask

    task automatic test_negative();
        step('0, 1'b0, 1'b1);
        for (int n = 0; n <= 6; n++) begin
            step(5'(-(n + 1)), 1'b1, 1'b0);
            checks++;
            if (got !== want_vec()) begin
                errors++;
                $display("FAIL neg n=%0d got %h want %h",
                         n, got, want_vec());
            end
        end
        checks++;
        if ({out_valid, x_6k, x_6k_3, x_6k_4, x_6k_5, k_idx} !==
            {1'b1, 5'b11001, 5'b11100, 5'b11101, 5'b11110, 8'd1}) begin
            errors++;
            $display("FAIL neg_k1 got %b %h %h %h %h k=%0d",
                     out_valid, x_6k, x_6k_3, x_6k_4, x_6k_5, k_idx);
        end
    endtask

    task automatic test_sclr();
        step('0, 1'b0, 1'b1);
        for (int n = 0; n < 4; n++) step(5'(n + 1), 1'b1, 1'b0);
        step(5'sd5, 1'b1, 1'b1);
        checks++;
        if (got !== 31'd0) begin
            errors++;
            $display("FAIL sclr_clear got %h want 0", got);
        end
        for (int n = 0; n < 7; n++) begin
            step(5'(n + 1), 1'b1, 1'b0);
            checks++;
            if (got !== want_vec()) begin
                errors++;
                $display("FAIL sclr n=%0d got %h want %h",
                         n, got, want_vec());
            end
        end
        checks++;
        if ({x_6k, x_6k_3, x_6k_4, x_6k_5, k_idx} !==
            {5'd7, 5'd4, 5'd3, 5'd2, 8'd1}) begin
            errors++;
            $display("FAIL sclr_k1 got %h %h %h %h k=%0d",
                     x_6k, x_6k_3, x_6k_4, x_6k_5, k_idx);
        end
    endtask

    task automatic test_async_rst();
        step('0, 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) step(5'(n + 1), 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (got !== 31'd0) begin
            errors++;
            $display("FAIL async_rst got %h want 0", got);
        end
        model_clear();
        #1 rst = 1'b0;
        for (int n = 0; n <= 12; n++) begin
            step(5'(n + 1), 1'b1, 1'b0);
            checks++;
            if (got !== want_vec()) begin
                errors++;
                $display("FAIL restart n=%0d got %h want %h",
                         n, got, want_vec());
            end
        end
    endtask

    task automatic test_kwrap();
        logic [1:0] seq [0:4];
        int p;
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2;
        seq[3] = 2'd3; seq[4] = 2'd0;
        p = 0;
        step('0, 1'b0, 1'b1);
        for (int n = 0; n < 30; n++) begin
            step(5'($urandom), 1'b1, 1'b0);
            if (out_valid2 === 1'b1) begin
                checks++;
                if (p > 4 || k2_idx !== seq[p]) begin
                    errors++;
                    $display("FAIL kwrap pulse%0d got %0d want %0d",
                             p, k2_idx, seq[p % 5]);
                end
                p++;
            end
        end
        checks++;
        if (p != 5) begin
            errors++;
            $display("FAIL kwrap_pulses got %0d want 5", p);
        end
    endtask

    task automatic test_random();
        logic v, s;
        step('0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 59) == 0);
            step(5'($urandom), v, s);
            checks++;
            if (got !== want_vec()) begin
                errors++;
                $display("FAIL random i=%0d got %h want %h",
                         i, got, want_vec());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_ramp(0);
        test_ramp(3);
        test_negative();
        test_sclr();
        test_async_rst();
        test_kwrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
